// File: rtl/gpio_irq_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_irq_if
//  Description : Register bus between a host and the GPIO interrupt block.
//  Revision    : 1.0
// ============================================================================
interface gpio_irq_if;
    logic [3:0]  Addr;
    logic [15:0] DataRd;
    logic [15:0] DataWr;
    logic        En;
    logic        Rd;
    logic        Wr;

    modport master (
        output Addr,
        output DataWr,
        output En,
        output Rd,
        output Wr,
        input  DataRd
    );

    modport slave (
        input  Addr,
        input  DataWr,
        input  En,
        input  Rd,
        input  Wr,
        output DataRd
    );
endinterface
`default_nettype wire

// File: rtl/gpio_irq.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_irq
//  Description : Synchronised, glitch-filtered GPIO edge detector raising a
//                maskable interrupt, with a small register file.
//  Revision    : 1.0
// ============================================================================
module gpio_irq #(
    parameter int NUM_GPIO = 16,
    parameter int FILT_CNT = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    gpio_irq_if.slave           bus,
    input  logic [NUM_GPIO-1:0] P,
    output logic                Irq
);

    localparam logic [0:0] c_ST_WARMUP = 1'b0;
    localparam logic [0:0] c_ST_RUN    = 1'b1;
    localparam logic [1:0] c_WARM_LAST = 2'd2;
    localparam logic [3:0] c_FILT      = 4'(FILT_CNT);

    localparam logic [3:0] c_A_RISE = 4'd0;
    localparam logic [3:0] c_A_FALL = 4'd1;
    localparam logic [3:0] c_A_PEND = 4'd2;
    localparam logic [3:0] c_A_MASK = 4'd3;
    localparam logic [3:0] c_A_FLT  = 4'd4;
    localparam logic [3:0] c_A_S2   = 4'd5;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [1:0]          r_wcnt;
    logic [1:0]          w_wcnt_nxt;
    logic                w_warm;

    logic [NUM_GPIO-1:0] r_s1;
    logic [NUM_GPIO-1:0] r_s2;
    logic [NUM_GPIO-1:0] r_flt;
    logic [3:0]          r_cnt [NUM_GPIO];

    logic [NUM_GPIO-1:0] r_rise_en;
    logic [NUM_GPIO-1:0] r_fall_en;
    logic [NUM_GPIO-1:0] r_pend;
    logic [NUM_GPIO-1:0] r_mask;

    logic [NUM_GPIO-1:0] w_accept;
    logic [NUM_GPIO-1:0] w_set;
    logic [NUM_GPIO-1:0] w_clr;
    logic [NUM_GPIO-1:0] w_wdata;
    logic                w_wr;
    logic [15:0]         w_rd;

    // ---------------- controller: state register ----------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= c_ST_WARMUP;
            r_wcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // ---------------- controller: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            c_ST_WARMUP: begin
                if (r_wcnt == c_WARM_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_wcnt_nxt  = 2'd0;
                end else begin
                    w_wcnt_nxt  = r_wcnt + 2'd1;
                end
            end
            default: w_state_nxt = c_ST_RUN;
        endcase
    end

    // ---------------- controller: outputs ----------------
    always_comb begin
        w_warm = (r_state == c_ST_WARMUP);
    end

    // Warm-up lets Flt track the synchronizer so pins high at reset release
    // never look like an edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_flt <= '0;
            for (int i = 0; i < NUM_GPIO; i++) begin
                r_cnt[i] <= 4'd0;
            end
        end else begin
            r_s1 <= P;
            r_s2 <= r_s1;
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (w_warm || (r_s2[i] == r_flt[i])) begin
                    r_flt[i] <= r_s2[i];
                    r_cnt[i] <= 4'd0;
                end else if (r_cnt[i] == c_FILT) begin
                    r_flt[i] <= r_s2[i];
                    r_cnt[i] <= 4'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            w_accept[i] = !w_warm && (r_s2[i] != r_flt[i]) && (r_cnt[i] == c_FILT);
        end
    end

    assign w_set   = (w_accept & r_s2 & r_rise_en) | (w_accept & ~r_s2 & r_fall_en);
    assign w_wr    = bus.En && bus.Wr;
    assign w_wdata = bus.DataWr[NUM_GPIO-1:0];
    assign w_clr   = (w_wr && (bus.Addr == c_A_PEND)) ? w_wdata : '0;

    // A new event overrides a simultaneous write-1-to-clear.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_pend    <= '0;
            r_mask    <= '0;
        end else begin
            if (w_wr) begin
                case (bus.Addr)
                    c_A_RISE: r_rise_en <= w_wdata;
                    c_A_FALL: r_fall_en <= w_wdata;
                    c_A_MASK: r_mask    <= w_wdata;
                    default:  ;
                endcase
            end
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_rd = 16'd0;
        if (bus.En && bus.Rd) begin
            case (bus.Addr)
                c_A_RISE: w_rd = 16'(r_rise_en);
                c_A_FALL: w_rd = 16'(r_fall_en);
                c_A_PEND: w_rd = 16'(r_pend);
                c_A_MASK: w_rd = 16'(r_mask);
                c_A_FLT:  w_rd = 16'(r_flt);
                c_A_S2:   w_rd = 16'(r_s2);
                default:  w_rd = 16'd0;
            endcase
        end
    end

    assign bus.DataRd = w_rd;
    assign Irq        = |(r_pend & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_irq
//  Description : Directed bench for gpio_irq with a window-based pin model.
//  Revision    : 1.0
// ============================================================================
module tb_gpio_irq;

    localparam int c_N = 16;
    localparam int c_F = 3;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] P     = 16'h0000;
    logic        Irq;

    int total = 0;
    int bad   = 0;

    gpio_irq_if bus();

    gpio_irq #(.NUM_GPIO(c_N), .FILT_CNT(c_F)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave),
        .P     (P),
        .Irq   (Irq)
    );

    always #5 Clk = ~Clk;

    // Model: the filtered level flips once the synchronised level has
    // disagreed with it on each of the last FILT+1 run-mode edges.
    logic [15:0] m_s1 = '0, m_s2 = '0, m_flt = '0;
    logic [15:0] m_rise = '0, m_fall = '0, m_pend = '0, m_mask = '0;
    logic [15:0] m_hist [c_N];
    int          m_age = 0;
    logic        m_valid = 1'b0;

    logic [15:0] n_s1, n_s2, n_flt, n_rise, n_fall, n_pend, n_mask, n_set, n_clr;
    logic [15:0] n_hist [c_N];
    int          n_age;
    logic        differs;

    initial begin
        for (int i = 0; i < c_N; i++) m_hist[i] = '0;
    end

    always_comb begin
        n_s1    = P;
        n_s2    = m_s1;
        n_flt   = m_flt;
        n_rise  = m_rise;
        n_fall  = m_fall;
        n_mask  = m_mask;
        n_set   = '0;
        n_clr   = '0;
        n_age   = (m_age < 1000) ? m_age + 1 : m_age;
        differs = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            n_hist[i] = {m_hist[i][14:0], m_s2[i]};
            if (m_age < 3) begin
                n_flt[i] = m_s2[i];
            end else if (m_age >= 3 + c_F) begin
                differs = 1'b1;
                for (int j = 0; j <= c_F; j++) begin
                    if (n_hist[i][j] == m_flt[i]) differs = 1'b0;
                end
                if (differs) begin
                    n_flt[i] = m_s2[i];
                    if ((m_s2[i] && m_rise[i]) || (!m_s2[i] && m_fall[i])) n_set[i] = 1'b1;
                end
            end
        end
        if (bus.En && bus.Wr) begin
            case (bus.Addr)
                4'd0: n_rise = bus.DataWr;
                4'd1: n_fall = bus.DataWr;
                4'd2: n_clr  = bus.DataWr;
                4'd3: n_mask = bus.DataWr;
                default: ;
            endcase
        end
        n_pend = (m_pend & ~n_clr) | n_set;
        if (!Reset) begin
            n_s1 = '0; n_s2 = '0; n_flt = '0; n_rise = '0; n_fall = '0;
            n_pend = '0; n_mask = '0; n_age = 0;
            for (int i = 0; i < c_N; i++) n_hist[i] = '0;
        end
    end

    always @(posedge Clk) begin
        m_s1   <= n_s1;
        m_s2   <= n_s2;
        m_flt  <= n_flt;
        m_rise <= n_rise;
        m_fall <= n_fall;
        m_pend <= n_pend;
        m_mask <= n_mask;
        m_age  <= n_age;
        for (int i = 0; i < c_N; i++) m_hist[i] <= n_hist[i];
        if (!Reset) m_valid <= 1'b1;
    end

    function automatic logic [15:0] m_read(input logic en, input logic rd, input logic [3:0] a);
        logic [15:0] v;
        v = '0;
        if (en && rd) begin
            case (a)
                4'd0: v = m_rise;
                4'd1: v = m_fall;
                4'd2: v = m_pend;
                4'd3: v = m_mask;
                4'd4: v = m_flt;
                4'd5: v = m_s2;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (m_valid) begin
            check("model_irq", {15'd0, Irq}, {15'd0, |(m_pend & m_mask)});
            check("model_rd", bus.DataRd, m_read(bus.En, bus.Rd, bus.Addr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.Addr   = a;
        bus.DataWr = d;
        bus.En     = 1'b1;
        bus.Wr     = 1'b1;
        tick(1);
        bus.En     = 1'b0;
        bus.Wr     = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
        bus.Addr = a;
        bus.En   = 1'b1;
        bus.Rd   = 1'b1;
        #1;
        check(name, bus.DataRd, exp);
        bus.En   = 1'b0;
        bus.Rd   = 1'b0;
    endtask

    initial begin
        bus.Addr   = '0;
        bus.DataWr = '0;
        bus.En     = 1'b0;
        bus.Rd     = 1'b0;
        bus.Wr     = 1'b0;
        P          = 16'h0008;
        Reset      = 1'b0;
        tick(2);
        wr(4'd0, 16'hFFFF);
        for (int a = 0; a < 6; a++) rd_chk("reset_reg", 4'(a), 16'h0000);
        check("reset_irq", {15'd0, Irq}, 16'h0000);

        // pin already high at reset release
        Reset = 1'b1;
        wr(4'd0, 16'hFFFF);
        tick(10);
        rd_chk("no_event_high_at_release", 4'd2, 16'h0000);
        check("no_irq_high_at_release", {15'd0, Irq}, 16'h0000);
        rd_chk("flt_after_release", 4'd4, 16'h0008);

        P = 16'h0000;
        tick(8);
        wr(4'd0, 16'h0008);
        wr(4'd3, 16'h0008);
        rd_chk("fall_not_enabled", 4'd2, 16'h0000);

        // rise latency: Pend/Irq on the 6th edge exactly
        P = 16'h0008;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check("rise_latency_irq", {15'd0, Irq}, (k == 6) ? 16'h0001 : 16'h0000);
        end
        rd_chk("rise_pend", 4'd2, 16'h0008);
        wr(4'd2, 16'h0008);
        check("w1c_irq", {15'd0, Irq}, 16'h0000);

        // glitch filter on P[0]
        wr(4'd1, 16'h0001);
        P = 16'h0009;
        tick(8);
        rd_chk("flt_settled", 4'd4, 16'h0009);
        rd_chk("s2_settled", 4'd5, 16'h0009);
        P = 16'h0008;
        tick(3);
        P = 16'h0009;
        tick(8);
        rd_chk("short_pulse_flt", 4'd4, 16'h0009);
        rd_chk("short_pulse_pend", 4'd2, 16'h0000);
        P = 16'h0008;
        tick(4);
        P = 16'h0009;
        tick(8);
        rd_chk("long_pulse_pend", 4'd2, 16'h0001);
        wr(4'd2, 16'h0001);
        tick(8);

        // set wins over same-edge clear
        wr(4'd3, 16'h0001);
        P = 16'h0008;
        tick(5);
        wr(4'd2, 16'h0001);
        rd_chk("set_beats_clear", 4'd2, 16'h0001);
        check("set_beats_clear_irq", {15'd0, Irq}, 16'h0001);
        wr(4'd2, 16'h0001);
        rd_chk("later_clear", 4'd2, 16'h0000);
        check("later_clear_irq", {15'd0, Irq}, 16'h0000);
        P = 16'h0009;
        tick(8);

        // masking
        wr(4'd3, 16'h0000);
        wr(4'd0, 16'h0010);
        P = 16'h0019;
        tick(8);
        check("masked_irq", {15'd0, Irq}, 16'h0000);
        rd_chk("masked_pend", 4'd2, 16'h0010);
        wr(4'd3, 16'h0010);
        check("unmasked_irq", {15'd0, Irq}, 16'h0001);
        rd_chk("unmasked_pend", 4'd2, 16'h0010);
        wr(4'd0, 16'h0000);
        rd_chk("pend_kept_after_en_clear", 4'd2, 16'h0010);
        wr(4'd2, 16'h0010);
        rd_chk("unmapped_read", 4'd7, 16'h0000);
        wr(4'd4, 16'h0000);
        rd_chk("ro_write_ignored", 4'd4, 16'h0019);

        // reset in the middle of a filter count
        wr(4'd0, 16'h0020);
        P = 16'h0039;
        tick(4);
        Reset = 1'b0;
        tick(1);
        Reset = 1'b1;
        for (int a = 0; a < 6; a++) rd_chk("midcount_reset_reg", 4'(a), 16'h0000);
        wr(4'd0, 16'h0020);
        tick(12);
        rd_chk("midcount_no_event", 4'd2, 16'h0000);
        rd_chk("midcount_flt", 4'd4, 16'h0039);
        check("midcount_irq", {15'd0, Irq}, 16'h0000);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_irq.md
GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 16, meaning the number of monitored pins (1..16).
REQ-002 SHALL have parameter FILT_CNT, default 3, meaning extra stable cycles required before a level change is accepted (0..15).
REQ-003 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port Addr, input, 4, register select.
REQ-006 SHALL have port DataRd, output, 16, read data.
REQ-007 SHALL have port DataWr, input, 16, write data.
REQ-008 SHALL have ports En, Rd and Wr, input, 1 each, meaning block select, read strobe and write strobe.
REQ-009 SHALL have port P, input, NUM_GPIO, meaning the GPIO pin levels, the same nets the GPIO block drives or reads.
REQ-010 SHALL have port Irq, output, 1, active-high interrupt request.

Function
REQ-011 SHALL pass each P bit through a two-flop synchronizer (S1 then S2).
REQ-012 SHALL keep a filtered level Flt[i] and a 4-bit counter Cnt[i] per pin, updated at each clock edge as follows:
- S2==Flt: Cnt<=0.
- Else, Cnt==FILT_CNT: Flt<=S2 and Cnt<=0.
- Otherwise: Cnt<=Cnt+1.
REQ-013 SHALL reject any S2 excursion shorter than FILT_CNT+1 consecutive cycles; Flt does not change.
REQ-014 SHALL treat a 0->1 Flt update as a rise event and a 1->0 update as a fall event; the event is detected on the same edge that Flt updates.
REQ-015 SHALL set Pend[i] on a rise event when RiseEn[i]=1, or on a fall event when FallEn[i]=1.
REQ-016 SHALL give a latency of exactly FILT_CNT+3 edges from the first edge sampling a new stable pin level to Pend set (6 edges at default).
REQ-017 SHALL drive Irq combinationally as the OR of (Pend AND Mask) across all pins.
REQ-018 SHALL write the selected register at a Clk edge where En=1 and Wr=1; a write asserted for N cycles is applied N times.
REQ-019 SHALL use the following register map (bits at NUM_GPIO and above read 0 and ignore writes):
- 0: RiseEn, read/write.
- 1: FallEn, read/write.
- 2: Pend, read / write-1-to-clear.
- 3: Mask, read/write.
- 4: Flt, read-only.
- 5: S2, read-only.
REQ-020 SHALL drive DataRd combinationally with the selected register when En=1 and Rd=1, and 0 otherwise or for unmapped addresses 6..15.
REQ-021 SHALL let a set event win over a write-1-to-clear of the same Pend bit in the same cycle.
REQ-022 SHALL ignore writes to addresses 4, 5 and 6..15.
REQ-023 SHALL leave the Pend bits unchanged when the RiseEn, FallEn or Mask bits are cleared; only a write-1-to-clear clears Pend.
REQ-024 SHALL use a two-state controller:
- WARMUP: 3 cycles, counted by a 2-bit counter, during which Flt<=S2, Cnt<=0 and no events are generated.
- RUN: entered after WARMUP and held until the next reset.

Reset
REQ-025 SHALL, on a Clk edge with Reset=0, clear S1, S2, Flt, Cnt, RiseEn, FallEn, Pend and Mask to 0, and enter WARMUP with its counter at 0.
REQ-026 SHALL hold Irq at 0 from the reset edge until a Pend bit is set in RUN.
REQ-027 SHALL abort any in-progress filter count when reset is asserted mid-operation.
REQ-028 SHALL not produce an event for pins that were already high when reset was released.
REQ-029 SHALL ignore bus writes on reset edges.

Verification
REQ-030 SHALL cover default parameters, P[3] held 1 through reset release, then RiseEn=0xFFFF -> Pend=0x0000 and Irq=0 after 10 cycles.
REQ-031 SHALL cover RiseEn=0x0008 and Mask=0x0008, then P[3] 0->1 held -> Pend=0x0008 on the 6th edge and Irq=1 on that edge, not earlier.
REQ-032 SHALL cover FallEn=0x0001 with P[0]=1 settled, then a 3-cycle low pulse on P[0] -> Flt[0] stays 1 and Pend=0x0000; a 4-cycle low pulse -> Pend=0x0001.
REQ-033 SHALL cover a write of 0x0001 to address 2 on the same edge a new P[0] event sets Pend[0] -> Pend[0]=1 afterward, and a later clear-only write -> Pend[0]=0 and Irq=0.
REQ-034 SHALL cover Mask=0x0000 with Pend=0x0010 -> Irq=0, then a write of Mask=0x0010 -> Irq=1 combinationally after that edge, and a read of address 2 returning 0x0010.
REQ-035 SHALL cover Reset=0 for one edge while Cnt[5]=2 on a pending rise -> all registers read 0 and no event is produced for P[5] while it stays high.
